traffic_countdown_display: RTL and testbench

//  Downstream consumer of the one-way traffic light controller's red/yellow/green outputs.

---
 rtl/traffic_countdown_display.sv | 190 +++++++++++++++++++
 tb/tb_traffic_countdown_display.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_countdown_display.sv
// Two-digit BCD countdown of the current traffic-light phase, with sticky illegal-combination fault.
// Optional 7-segment decode is built when COUNTDOWN_SEG_EN is defined.
module traffic_countdown_display #(
    parameter int unsigned RED_SEC   = 30,
    parameter int unsigned RY_SEC    = 3,
    parameter int unsigned GRN_SEC   = 30,
    parameter int unsigned YEL_SEC   = 3,
    parameter int unsigned WARN_SEC  = 3,
    parameter int unsigned FAULT_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic       blank,
    output logic       warn,
    output logic       fault
);

    generate
        if (RED_SEC > 99 || RY_SEC > 99 || GRN_SEC > 99 || YEL_SEC > 99 || WARN_SEC > 99) begin : g_bad_sec
            $error("traffic_countdown_display: phase/warn seconds must be 0..99");
        end
        if (FAULT_CYC < 1) begin : g_bad_fault
            $error("traffic_countdown_display: FAULT_CYC must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        PH_OFF,
        PH_RED,
        PH_RY,
        PH_GRN,
        PH_YEL,
        PH_FAULT
    } phase_t;

    localparam int unsigned FW = (FAULT_CYC < 2) ? 1 : $clog2(FAULT_CYC + 1);
    localparam logic [FW-1:0] FCNT_LIM = FW'(FAULT_CYC);
    localparam logic [6:0]    WARN_V   = 7'(WARN_SEC);

    localparam logic [3:0] RED_T = 4'(RED_SEC / 10);
    localparam logic [3:0] RED_O = 4'(RED_SEC % 10);
    localparam logic [3:0] RY_T  = 4'(RY_SEC / 10);
    localparam logic [3:0] RY_O  = 4'(RY_SEC % 10);
    localparam logic [3:0] GRN_T = 4'(GRN_SEC / 10);
    localparam logic [3:0] GRN_O = 4'(GRN_SEC % 10);
    localparam logic [3:0] YEL_T = 4'(YEL_SEC / 10);
    localparam logic [3:0] YEL_O = 4'(YEL_SEC % 10);

    phase_t        phase_q, phase_d;
    logic [2:0]    lights_q, lights_d;
    logic [FW-1:0] fcnt_q, fcnt_d, fcnt_inc;
    logic [3:0]    tens_d, ones_d, dec_tens, dec_ones;
    logic          blank_d, warn_d, fault_d;
    logic          in_legal;
    phase_t        in_phase;
    logic [6:0]    count_val;

    // Input decode
    always_comb begin
        lights_d = {red, yellow, green};
        in_legal = 1'b1;
        in_phase = PH_OFF;
        case (lights_d)
            3'b000:  in_phase = PH_OFF;
            3'b100:  in_phase = PH_RED;
            3'b110:  in_phase = PH_RY;
            3'b001:  in_phase = PH_GRN;
            3'b010:  in_phase = PH_YEL;
            default: in_legal = 1'b0;
        endcase
    end

    // Saturating BCD decrement
    always_comb begin
        dec_tens = tens;
        dec_ones = ones;
        if (ones != 4'd0) begin
            dec_ones = ones - 4'd1;
        end else if (tens != 4'd0) begin
            dec_tens = tens - 4'd1;
            dec_ones = 4'd9;
        end
    end

    assign fcnt_inc = fcnt_q + 1'b1;

    // Next phase / count. Reload also requires a phase change, so returning to
    // the same phase after a short illegal glitch keeps counting down.
    always_comb begin
        phase_d = phase_q;
        tens_d  = dec_tens;
        ones_d  = dec_ones;
        fcnt_d  = fcnt_q;
        if (phase_q == PH_FAULT) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (!in_legal) begin
            if (fcnt_inc >= FCNT_LIM) begin
                phase_d = PH_FAULT;
                tens_d  = 4'd0;
                ones_d  = 4'd0;
            end else begin
                fcnt_d = fcnt_inc;
            end
        end else begin
            fcnt_d = '0;
            if (lights_d != lights_q && in_phase != phase_q) begin
                phase_d = in_phase;
                case (in_phase)
                    PH_RED:  begin tens_d = RED_T; ones_d = RED_O; end
                    PH_RY:   begin tens_d = RY_T;  ones_d = RY_O;  end
                    PH_GRN:  begin tens_d = GRN_T; ones_d = GRN_O; end
                    PH_YEL:  begin tens_d = YEL_T; ones_d = YEL_O; end
                    default: begin tens_d = 4'd0;  ones_d = 4'd0;  end
                endcase
            end
        end
    end

    always_comb begin
        count_val = {3'b000, tens_d} * 7'd10 + {3'b000, ones_d};
        blank_d   = (phase_d == PH_OFF) || (phase_d == PH_FAULT);
        fault_d   = (phase_d == PH_FAULT);
        warn_d    = !blank_d && (count_val <= WARN_V);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= PH_OFF;
            lights_q <= '0;
            fcnt_q   <= '0;
            tens     <= '0;
            ones     <= '0;
            blank    <= 1'b1;
            warn     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            lights_q <= lights_d;
            fcnt_q   <= fcnt_d;
            tens     <= tens_d;
            ones     <= ones_d;
            blank    <= blank_d;
            warn     <= warn_d;
            fault    <= fault_d;
        end
    end

`ifdef COUNTDOWN_SEG_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Tens digit dark when zero to suppress the leading zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_tens <= '0;
            seg_ones <= '0;
        end else begin
            seg_tens <= (blank_d || tens_d == 4'd0) ? 7'h00 : seg7(tens_d);
            seg_ones <= blank_d ? 7'h00 : seg7(ones_d);
        end
    end
`else
    assign seg_tens = 7'h00;
    assign seg_ones = 7'h00;
`endif

endmodule

// File: tb/tb_traffic_countdown_display.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a monitor pops and compares each cycle.
module tb_traffic_countdown_display;

    localparam int RED_S = 30, RY_S = 3, GRN_S = 30, YEL_S = 3, WARN_S = 3, FCYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       red = 1'b0, yellow = 1'b0, green = 1'b0;
    logic [3:0] tens, ones;
    logic [6:0] seg_tens, seg_ones;
    logic       blank, warn, fault;

    traffic_countdown_display #(
        .RED_SEC(RED_S), .RY_SEC(RY_S), .GRN_SEC(GRN_S),
        .YEL_SEC(YEL_S), .WARN_SEC(WARN_S), .FAULT_CYC(FCYC)
    ) dut (
        .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
        .tens(tens), .ones(ones), .seg_tens(seg_tens), .seg_ones(seg_ones),
        .blank(blank), .warn(warn), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] o;
        logic [6:0] st;
        logic [6:0] so;
        logic       b;
        logic       w;
        logic       f;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [6:0] segtab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model: phase 0 OFF, 1 RED, 2 RY, 3 GRN, 4 YEL, 5 FAULT; rem = seconds left
    int m_phase = 0;
    int m_rem   = 0;
    int m_bad   = 0;
    int dur[5]  = '{0, RED_S, RY_S, GRN_S, YEL_S};

    function automatic int phase_of(input logic [2:0] l);
        case (l)
            3'b000:  return 0;
            3'b100:  return 1;
            3'b110:  return 2;
            3'b001:  return 3;
            3'b010:  return 4;
            default: return -1;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.t = 4'(m_rem / 10);
        e.o = 4'(m_rem % 10);
        e.b = (m_phase == 0 || m_phase == 5);
        e.f = (m_phase == 5);
        e.w = !e.b && (m_rem <= WARN_S);
`ifdef COUNTDOWN_SEG_EN
        e.st = (e.b || m_rem < 10) ? 7'h00 : segtab[m_rem / 10];
        e.so = e.b ? 7'h00 : segtab[m_rem % 10];
`else
        e.st = 7'h00;
        e.so = 7'h00;
`endif
        return e;
    endfunction

    function automatic void model_step(input logic [2:0] l);
        int p;
        p = phase_of(l);
        if (m_phase == 5) begin
            m_rem = 0;
        end else if (p < 0) begin
            m_bad++;
            if (m_bad >= FCYC) begin
                m_phase = 5;
                m_rem   = 0;
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end else begin
            m_bad = 0;
            if (p != m_phase) begin
                m_phase = p;
                m_rem   = dur[p];
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end
    endfunction

    task automatic compare(input string name, input exp_t act, input exp_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got t=%0d o=%0d st=%h so=%h b=%b w=%b f=%b, want t=%0d o=%0d st=%h so=%h b=%b w=%b f=%b",
                     name, act.t, act.o, act.st, act.so, act.b, act.w, act.f,
                     exp.t, exp.o, exp.st, exp.so, exp.b, exp.w, exp.f);
        end
    endtask

    function automatic exp_t dut_out();
        exp_t a;
        a = '{t: tens, o: ones, st: seg_tens, so: seg_ones, b: blank, w: warn, f: fault};
        return a;
    endfunction

    // Monitor: the DUT presents a new output every cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) compare("cycle", dut_out(), q.pop_front());
        end
    end

    task automatic step(input logic [2:0] l);
        @(negedge clk);
        {red, yellow, green} = l;
        model_step(l);
        q.push_back(model_out());
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset(input string name);
        exp_t r;
        drain();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        m_phase = 0; m_rem = 0; m_bad = 0;
        r = '{t: 4'd0, o: 4'd0, st: 7'h00, so: 7'h00, b: 1'b1, w: 1'b0, f: 1'b0};
        compare(name, dut_out(), r);
        {red, yellow, green} = 3'b000;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] legal_tab[5] = '{3'b000, 3'b100, 3'b110, 3'b001, 3'b010};
        logic [2:0] bad_tab[3]   = '{3'b011, 3'b101, 3'b111};
        logic [2:0] l;
        int         hold;

        do_reset("reset_initial");

        // Full RED countdown into saturation
        repeat (33) step(3'b100);
        // RED -> RY -> GRN -> YEL
        repeat (5) step(3'b100);
        repeat (4) step(3'b110);
        repeat (3) step(3'b001);
        repeat (5) step(3'b010);

        // Reset mid-countdown at 17, then release into GRN
        step(3'b001);
        for (int i = 0; i < 40 && m_rem != 17; i++) step(3'b001);
        do_reset("reset_mid_count");
        // GRN down to 07 and past it
        repeat (26) step(3'b001);

        for (int blk = 0; blk < 4; blk++) begin
            do_reset("reset_random_block");
            for (int n = 0; n < 120; ) begin
                if ($urandom_range(0, 9) == 0) begin
                    l    = bad_tab[$urandom_range(0, 2)];
                    hold = $urandom_range(1, 2);
                end else begin
                    l    = legal_tab[$urandom_range(0, 4)];
                    hold = $urandom_range(1, 8);
                end
                repeat (hold) step(l);
                n += hold;
            end
        end

        // Short glitch tolerated, persistent illegal value latches the fault
        do_reset("reset_before_fault");
        repeat (6) step(3'b100);
        step(3'b101);
        repeat (4) step(3'b100);
        repeat (2) step(3'b111);
        step(3'b100);
        step(3'b001);
        step(3'b000);
        repeat (3) step(3'b010);

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
